im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Writer-side counterpart to the CPU's instruction-memory read path.
- Receives a framed byte stream over a valid/ready link, packs bytes big-endian into 32-bit instruction words and writes them sequentially into the instruction memory.
- Holds the CPU in reset until a complete, checksum-verified image has been written.
- Sits between the host/debug byte link and the IM write port; its cpu_hold output is ORed into the CPU reset.

Parameters:
- ADDR_W, 10: IM word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  byte accepted when in_valid and in_ready are both high on a clk edge
- reload  in  1  single-cycle request to abort or restart and re-hold the CPU
- im_we  out  1  IM write enable, one-cycle pulse per word
- im_addr  out  ADDR_W  IM word address
- im_wdata  out  32  IM write data
- cpu_hold  out  1  high keeps the CPU in reset
- done  out  1  image loaded and checksum OK
- err  out  1  length or checksum error
- words_loaded  out  ADDR_W+1  count of words written in the current load

Behaviour:
- Frame format:
  - LEN_HI, LEN_LO: word count N, 16-bit, big-endian.
  - 4N data bytes, MSB first per word.
  - One checksum byte, chosen so the 8-bit sum of all frame bytes (length bytes and checksum included) is 0x00 mod 256.
- States: S_LEN_HI, S_LEN_LO, S_DATA, S_SUM, S_DONE, S_ERR.
- Reset (async) values:
  - state = S_LEN_HI.
  - cpu_hold = 1.
  - im_we = 0, im_addr = 0, im_wdata = 0.
  - done = 0, err = 0, words_loaded = 0.
  - Running sum and byte counter cleared.
- in_ready:
  - Combinational: 1 in S_LEN_HI, S_LEN_LO, S_DATA, S_SUM when reload = 0.
  - 0 in S_DONE and S_ERR, and in any cycle where reload = 1.
- Every accepted byte is added to the running 8-bit sum, with wrap-around.
- S_LEN_HI, on byte: latch N[15:8], go to S_LEN_LO.
- S_LEN_LO, on byte: latch N[7:0], then:
  - if N > 2^ADDR_W: go to S_ERR;
  - else if N = 0: go to S_SUM;
  - else go to S_DATA.
- S_DATA:
  - A 2-bit byte index shifts each byte into a 32-bit assembly register.
  - On the 4th byte, the next cycle has im_we = 1, im_addr = words_loaded, and im_wdata = the assembled word; words_loaded then increments. Latency is 1 clk from the accepting edge to the im_we cycle.
  - After word N-1 is accepted, go to S_SUM.
  - Gaps in in_valid are allowed anywhere; state holds.
- S_SUM, on byte:
  - If the sum including this byte is 0x00: go to S_DONE. On the next edge done = 1 and cpu_hold = 0.
  - Otherwise go to S_ERR: err = 1, cpu_hold stays 1.
- Words already written stay in the IM on error; there is no rollback.
- S_DONE and S_ERR are sticky until reload or rst.
- reload, in any state:
  - Next state is S_LEN_HI; cpu_hold = 1; done = 0; err = 0.
  - words_loaded, sum and byte index are cleared.
  - A pending im_we in the same cycle still completes.
  - reload takes priority over a simultaneous byte, which is not accepted (in_ready = 0).
- im_we never asserts outside S_DATA word completion. im_addr never exceeds 2^ADDR_W - 1.

Decomposition:
- Shared package im_loader_pkg holds:
  - the state enum;
  - SUM_OK = 8'h00;
  - LEN_W = 16;
  - a function for max words from ADDR_W.
- One natural sub-module: im_word_packer, which takes a byte, the load strobe and a clear, and produces word_valid and word[31:0] from a 4-byte big-endian shift register with an index counter.

Test Plan:
- Reset: after rst falls, cpu_hold=1, in_ready=1, im_we=0, done=0, err=0, words_loaded=0.
- Good load, N=2: send bytes 00 02 3C 01 00 01 34 21 00 02 69.
  - im_we pulses twice: addr 0 / 0x3C010001, then addr 1 / 0x34210002.
  - Then done=1, cpu_hold=0, words_loaded=2, in_ready=0.
- Bad checksum: same frame with last byte 6A.
  - Both words are still written.
  - err=1, done=0, cpu_hold=1; stays there until reload.
- Empty image: send 00 00 00, giving done=1, cpu_hold=0, no im_we.
- Length overflow (ADDR_W=10): send 04 01.
  - err=1 after the second byte, in_ready=0, no im_we.
- Mid-frame reload with stalls:
  - Start the good frame with random in_valid gaps; assert reload after 5 bytes, concurrent with a valid byte.
  - That byte is not accepted; state restarts.
  - Resending the full good frame yields done=1, words_loaded=2.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes,
// frame constants and the capacity helper.
package im_loader_pkg;

   localparam int         LEN_W  = 16;
   localparam logic [7:0] SUM_OK = 8'h00;

   typedef logic [2:0] state_t;

   localparam state_t S_LEN_HI = 3'd0;
   localparam state_t S_LEN_LO = 3'd1;
   localparam state_t S_DATA   = 3'd2;
   localparam state_t S_SUM    = 3'd3;
   localparam state_t S_DONE   = 3'd4;
   localparam state_t S_ERR    = 3'd5;

   // Largest legal word count for an IM with aw address bits.
   function automatic logic [LEN_W:0] max_words(input int aw);
      return (LEN_W+1)'(1) << aw;
   endfunction

endpackage

// File: rtl/im_word_packer.sv
// Packs bytes MSB-first into 32-bit words; word_valid pulses for one cycle
// after the fourth byte of each word is loaded.
module im_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        load,
   input  logic        clear,
   output logic [1:0]  idx,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [23:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= 2'd0;
         word_valid <= 1'b0;
         word       <= 32'd0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            idx <= 2'd0;
         end else if (load) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
               word_valid <= 1'b1;
               word       <= {sr, din};
            end
         end
      end
   end

   // The first three bytes of a word only need to be held, never reset.
   always_ff @(posedge clk) begin
      if (load) sr <= {sr[15:0], din};
   end

endmodule

// File: rtl/im_loader.sv
// Frame-driven instruction-memory loader: writes a length-prefixed,
// checksummed image into the IM and holds the CPU until it verifies.
module im_loader
   import im_loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   state_t           state;
   logic [7:0]       sum;
   logic [7:0]       sum_next;
   logic [7:0]       n_hi;
   logic [LEN_W-1:0] n_words;
   logic [LEN_W-1:0] n_next;
   logic [1:0]       idx;
   logic             accept;
   logic             last_word;

   assign in_ready = ~reload & ((state == S_LEN_HI) | (state == S_LEN_LO) |
                                (state == S_DATA)   | (state == S_SUM));
   assign accept   = in_valid & in_ready;
   assign sum_next = sum + in_data;
   assign n_next   = {n_hi, in_data};
   assign im_addr  = words_loaded[ADDR_W-1:0];

   // Words are at least four accepts apart, so words_loaded is already
   // up to date whenever the final byte of a word arrives.
   assign last_word = (idx == 2'd3) &&
                      (((LEN_W+1)'(words_loaded) + (LEN_W+1)'(1)) == {1'b0, n_words});

   im_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .din        (in_data),
      .load       (accept && (state == S_DATA)),
      .clear      (reload),
      .idx        (idx),
      .word_valid (im_we),
      .word       (im_wdata)
   );

   always_ff @(posedge clk) begin
      if (accept && (state == S_LEN_HI)) n_hi    <= in_data;
      if (accept && (state == S_LEN_LO)) n_words <= n_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_LEN_HI;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
         sum          <= 8'd0;
      end else if (reload) begin
         state        <= S_LEN_HI;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
         sum          <= 8'd0;
      end else begin
         if (im_we) words_loaded <= words_loaded + (ADDR_W+1)'(1);
         if (accept) begin
            sum <= sum_next;
            case (state)
               S_LEN_HI: state <= S_LEN_LO;
               S_LEN_LO: begin
                  if ({1'b0, n_next} > max_words(ADDR_W)) begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end else if (n_next == '0) begin
                     state <= S_SUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: if (last_word) state <= S_SUM;
               S_SUM: begin
                  if (sum_next == SUM_OK) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_im_loader;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              reload;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   int checks = 0;
   int fails  = 0;

   logic [ADDR_W-1:0] wa_q[$];
   logic [31:0]       wd_q[$];

   logic [7:0] good[11] = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01,
                            8'h34, 8'h21, 8'h00, 8'h02, 8'h69};

   im_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .reload       (reload),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (im_we) begin
         wa_q.push_back(im_addr);
         wd_q.push_back(im_wdata);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int gap;
      int cnt;
      gap = $urandom_range(maxgap, 0);
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      cnt = 0;
      while (!in_ready && cnt < 50) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      if (!in_ready) begin
         checks++;
         fails++;
         $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      @(negedge clk);
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_cpu_hold: got %0b want 1", cpu_hold); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      checks++; if (im_we !== 1'b0) begin fails++; $display("FAIL reset_im_we: got %0b want 0", im_we); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_done_err: got %0b/%0b want 0/0", done, err); end
      checks++; if (words_loaded !== '0) begin fails++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
   endtask

   task automatic test_good_load();
      foreach (good[i]) send_byte(good[i], 0);
      repeat (3) @(negedge clk);
      checks++; if (wa_q.size() !== 2) begin fails++; $display("FAIL good_we_count: got %0d want 2", wa_q.size()); end
      if (wa_q.size() == 2) begin
         checks++; if (wa_q[0] !== 10'd0 || wd_q[0] !== 32'h3C010001) begin fails++; $display("FAIL good_word0: got %0d/%h want 0/3c010001", wa_q[0], wd_q[0]); end
         checks++; if (wa_q[1] !== 10'd1 || wd_q[1] !== 32'h34210002) begin fails++; $display("FAIL good_word1: got %0d/%h want 1/34210002", wa_q[1], wd_q[1]); end
      end
      checks++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL good_done_err: got %0b/%0b want 1/0", done, err); end
      checks++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL good_cpu_hold: got %0b want 0", cpu_hold); end
      checks++; if (words_loaded !== 11'd2) begin fails++; $display("FAIL good_words: got %0d want 2", words_loaded); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL good_in_ready: got %0b want 0", in_ready); end
   endtask

   task automatic test_bad_sum();
      for (int i = 0; i < 10; i++) send_byte(good[i], 1);
      send_byte(8'h6A, 1);
      repeat (3) @(negedge clk);
      checks++; if (wa_q.size() !== 2) begin fails++; $display("FAIL bad_we_count: got %0d want 2", wa_q.size()); end
      checks++; if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL bad_err_done: got %0b/%0b want 1/0", err, done); end
      checks++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL bad_cpu_hold: got %0b want 1", cpu_hold); end
      repeat (6) @(negedge clk);
      checks++; if (err !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL bad_sticky: err=%0b in_ready=%0b want 1/0", err, in_ready); end
   endtask

   task automatic test_empty();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL empty_done: done=%0b hold=%0b want 1/0", done, cpu_hold); end
      checks++; if (wa_q.size() !== 0) begin fails++; $display("FAIL empty_no_we: got %0d writes want 0", wa_q.size()); end
   endtask

   task automatic test_overflow();
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      @(negedge clk);
      checks++; if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL ovf_err: got %0b/%0b want 1/0", err, done); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ovf_in_ready: got %0b want 0", in_ready); end
      repeat (3) @(negedge clk);
      checks++; if (wa_q.size() !== 0 || cpu_hold !== 1'b1) begin fails++; $display("FAIL ovf_no_we: writes=%0d hold=%0b want 0/1", wa_q.size(), cpu_hold); end
   endtask

   task automatic test_reload_stall();
      for (int i = 0; i < 5; i++) send_byte(good[i], 3);
      @(negedge clk);
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = good[5];
      #1;
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reload_in_ready: got %0b want 0", in_ready); end
      @(posedge clk);
      #1;
      reload   = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (words_loaded !== '0 || done !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b1) begin
         fails++; $display("FAIL reload_restart: wl=%0d done=%0b err=%0b hold=%0b want 0/0/0/1", words_loaded, done, err, cpu_hold);
      end
      checks++; if (in_ready !== 1'b1 || wa_q.size() !== 0) begin fails++; $display("FAIL reload_idle: rdy=%0b writes=%0d want 1/0", in_ready, wa_q.size()); end
      foreach (good[i]) send_byte(good[i], 3);
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b1 || words_loaded !== 11'd2) begin fails++; $display("FAIL reload_resend: done=%0b wl=%0d want 1/2", done, words_loaded); end
      checks++; if (wa_q.size() !== 2) begin fails++; $display("FAIL reload_we_count: got %0d want 2", wa_q.size()); end
      else if (wd_q[0] !== 32'h3C010001 || wd_q[1] !== 32'h34210002) begin
         checks++; fails++; $display("FAIL reload_words: got %h %h want 3c010001 34210002", wd_q[0], wd_q[1]);
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 10; f++) begin
         logic [7:0] fr[$];
         logic [31:0] exp_w[$];
         int kind, n, s;
         logic exp_done, exp_err;
         int exp_wl;
         fr.delete();
         exp_w.delete();
         kind = $urandom_range(0, 5);
         if (kind == 0) begin
            n = 1025 + $urandom_range(0, 3000);
            fr.push_back(8'((n >> 8) & 255));
            fr.push_back(8'(n & 255));
            exp_done = 1'b0; exp_err = 1'b1; exp_wl = 0;
         end else begin
            n = $urandom_range(0, 5);
            fr.push_back(8'((n >> 8) & 255));
            fr.push_back(8'(n & 255));
            for (int w = 0; w < n; w++) begin
               int b0, b1, b2, b3;
               b0 = $urandom_range(0, 255); b1 = $urandom_range(0, 255);
               b2 = $urandom_range(0, 255); b3 = $urandom_range(0, 255);
               fr.push_back(8'(b0)); fr.push_back(8'(b1)); fr.push_back(8'(b2)); fr.push_back(8'(b3));
               exp_w.push_back(32'(b0 * 16777216 + b1 * 65536 + b2 * 256 + b3));
            end
            s = 0;
            foreach (fr[i]) s += fr[i];
            s = (256 - (s % 256)) % 256;
            if (kind == 1) s = (s + $urandom_range(1, 255)) % 256;
            fr.push_back(8'(s));
            exp_done = (kind != 1); exp_err = (kind == 1); exp_wl = n;
         end
         foreach (fr[i]) send_byte(fr[i], 2);
         repeat (3) @(negedge clk);
         checks++; if (wa_q.size() !== exp_w.size()) begin fails++; $display("FAIL rand%0d_we_count: got %0d want %0d", f, wa_q.size(), exp_w.size()); end
         else begin
            foreach (exp_w[i]) begin
               checks++;
               if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_w[i]) begin
                  fails++; $display("FAIL rand%0d_word%0d: got %0d/%h want %0d/%h", f, i, wa_q[i], wd_q[i], i, exp_w[i]);
               end
            end
         end
         checks++; if (done !== exp_done || err !== exp_err || cpu_hold !== !exp_done) begin
            fails++; $display("FAIL rand%0d_status: done=%0b err=%0b hold=%0b want %0b/%0b/%0b", f, done, err, cpu_hold, exp_done, exp_err, !exp_done);
         end
         checks++; if (words_loaded !== 11'(exp_wl)) begin fails++; $display("FAIL rand%0d_words: got %0d want %0d", f, words_loaded, exp_wl); end
         do_reload();
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'd0;
      reload   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_good_load();
      do_reload();
      test_bad_sum();
      do_reload();
      test_empty();
      do_reload();
      test_overflow();
      do_reload();
      test_reload_stall();
      do_reload();
      test_random_frames();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
